stall_ctrl: RTL and testbench
=============================

// Module: stall_ctrl
// PURPOSE
//  Pipeline hazard controller for the 5-stage MIPS core. Decides each cycle whether the
//  D-stage instruction must wait: data hazards (Tuse/Tnew) or a busy mult/div unit.
//  Drives IFU freeze, the F/D register enable and the D/E register flush.
//  Owns the mult/div busy timer and a saturating stall-cycle performance counter.
// PARAMETERS
//  MULT_LAT  5   cycles mult/multu occupies HI/LO after its start cycle
//  DIV_LAT   10  cycles div/divu occupies HI/LO after its start cycle
//  CNT_W     4   width of busy timer; must hold max(MULT_LAT,DIV_LAT)
// PORTS
//  clk          in   1   core clock; all state updates on posedge
//  reset        in   1   synchronous, active-high
//  D_rs         in   5   D-stage rs register number
//  D_rt         in   5   D-stage rt register number
//  D_Tuse_rs    in   2   cycles until D needs rs (3 = not used)
//  D_Tuse_rt    in   2   cycles until D needs rt (3 = not used)
//  D_is_md      in   1   D instr is mult/div/mfhi/mflo/mthi/mtlo
//  E_wa         in   5   E-stage destination register (0 = none)
//  E_Tnew       in   2   cycles until E result is forwardable
//  M_wa         in   5   M-stage destination register (0 = none)
//  M_Tnew       in   2   cycles until M result is forwardable
//  E_md_start   in   1   E instr is starting mult/div this cycle
//  E_md_div     in   1   with E_md_start: 1 = div/divu, 0 = mult/multu
//  freeze       out  1   to IFU: hold PC
//  D_en         out  1   F/D pipeline register write enable
//  E_flush      out  1   D/E register loads a bubble (nop)
//  md_busy      out  1   mult/div unit occupied
//  stall_cycles out  32  count of cycles with stall asserted
// BEHAVIOUR
//  - Reset: timer=0, stall_cycles=0; reset beats E_md_start same cycle. After reset:
//    md_busy=0, freeze=0, D_en=1, E_flush=0 (given quiet inputs).
//  - stall_rs = (D_rs!=0) & ((D_rs==E_wa & D_Tuse_rs<E_Tnew) | (D_rs==M_wa & D_Tuse_rs<M_Tnew)).
//  - stall_rt likewise with D_rt/D_Tuse_rt. Register 0 never stalls.
//  - md_busy = E_md_start | (timer!=0); stall_md = D_is_md & md_busy.
//  - stall = stall_rs | stall_rt | stall_md; purely combinational from inputs+state,
//    same-cycle effect: freeze=stall, D_en=~stall, E_flush=stall.
//  - Timer (posedge): reset -> 0; else E_md_start -> DIV_LAT or MULT_LAT per E_md_div;
//    else timer!=0 -> timer-1; else hold 0. md_busy high for 1+LAT cycles per start.
//  - E_md_start while timer!=0 (not legal when D-stall works): reload, no error flag.
//  - stall_cycles: +1 each cycle stall=1; saturates at 32'hFFFF_FFFF, never wraps.
//  - Unsigned 2-bit compares; Tnew=0 never stalls. Reset mid-busy drops busy next cycle.
// STRUCTURE
//  - hazard_pkg: TUSE_NONE=2'd3, Tnew encodings, MULT_LAT/DIV_LAT defaults.
//  - One sub-module: md_busy_timer (load/decrement timer, emits md_busy).
//  - Hazard compare logic and perf counter stay in stall_ctrl.
// TESTING
//  1 E_wa=5,E_Tnew=2,D_rs=5,D_Tuse_rs=1 -> freeze=1,D_en=0,E_flush=1 same cycle; stall_cycles+1.
//  2 D_rs=0,E_wa=0,E_Tnew=2,D_Tuse_rs=0 -> no stall; M_wa=7,M_Tnew=1,D_rt=7,Tuse_rt=0 -> stall.
//  3 E_md_start=1,E_md_div=0, D_is_md=1 held -> stall 6 cycles, released on 7th; md_busy same span.
//  4 E_md_start=1,E_md_div=1 -> md_busy 11 cycles; non-md D instr never stalls meanwhile.
//  5 reset pulsed 3 cycles into div -> md_busy=0, stall_cycles=0 cycle after reset edge.
//  6 force stall_cycles=32'hFFFF_FFFE, stall 3 cycles -> reads 32'hFFFF_FFFF, holds.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings and default latencies for the D-stage hazard controller.
package hazard_pkg;

  // Tuse value meaning "this operand is not read by the D instruction".
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Tnew encodings: cycles until a producer's result reaches a forwarding point.
  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  // Mult/div occupancy of HI/LO after the start cycle.
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;
  localparam int CNT_W_DEF    = 4;

  typedef enum logic {
    MD_MULT = 1'b0,
    MD_DIV  = 1'b1
  } md_op_e;

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div occupancy timer: loads the operation latency on a start and counts
// down to zero. md_busy covers the start cycle plus LAT following cycles.
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic md_busy
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_LAT);

  logic [CNT_W-1:0] timer_q;

  // ---- registered state: reload on start (a restart simply reloads), else count down
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else if (start) begin
      timer_q <= (md_op_e'(is_div) == MD_DIV) ? DIV_LD : MULT_LD;
    end else if (timer_q != '0) begin
      timer_q <= timer_q - 1'b1;
    end
  end

  // ---- combinational output: busy already in the start cycle itself
  assign md_busy = start | (timer_q != '0);

endmodule

// File: rtl/stall_ctrl.sv
// D-stage hazard controller for the 5-stage MIPS core. Stalls the D instruction
// on Tuse/Tnew data hazards or when it needs HI/LO while mult/div is busy, and
// keeps a saturating count of stalled cycles.
module stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic        D_is_md,
  input  logic [4:0]  E_wa,
  input  logic [1:0]  E_Tnew,
  input  logic [4:0]  M_wa,
  input  logic [1:0]  M_Tnew,
  input  logic        E_md_start,
  input  logic        E_md_div,
  output logic        freeze,
  output logic        D_en,
  output logic        E_flush,
  output logic        md_busy,
  output logic [31:0] stall_cycles
);

  logic        stall_rs;
  logic        stall_rt;
  logic        stall_md;
  logic        stall;
  logic [31:0] stall_cnt_q;

  // Operand needed sooner than the producer can supply it. Unsigned compare:
  // Tnew=0 never stalls and Tuse=TUSE_NONE (3) can never be below a Tnew.
  function automatic logic hazard(input logic [4:0] src, input logic [1:0] tuse,
                                  input logic [4:0] wa,  input logic [1:0] tnew);
    return (src == wa) && (tuse < tnew);
  endfunction

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  md_busy_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_busy_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (E_md_start),
    .is_div  (E_md_div),
    .md_busy (md_busy)
  );

  // ---- combinational decision: same-cycle effect on IFU, F/D and D/E
  always_comb begin
    stall_rs = (D_rs != 5'd0) &&
               (hazard(D_rs, D_Tuse_rs, E_wa, E_Tnew) || hazard(D_rs, D_Tuse_rs, M_wa, M_Tnew));
    stall_rt = (D_rt != 5'd0) &&
               (hazard(D_rt, D_Tuse_rt, E_wa, E_Tnew) || hazard(D_rt, D_Tuse_rt, M_wa, M_Tnew));
    stall_md = D_is_md & md_busy;
    stall    = stall_rs | stall_rt | stall_md;
  end

  assign freeze  = stall;
  assign D_en    = ~stall;
  assign E_flush = stall;

  // ---- registered state: stalled-cycle performance counter
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else if (stall) begin
      stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-indexed reference model.
module tb_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs, D_rt, E_wa, M_wa;
  logic [1:0]  D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic        D_is_md, E_md_start, E_md_div;
  logic        freeze, D_en, E_flush, md_busy;
  logic [31:0] stall_cycles;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  int          cyc       = 0;
  bit          have_md   = 1'b0;
  int          md_start  = 0;
  int          md_lat    = 0;
  logic [31:0] m_cnt     = 32'd0;

  // last observed outputs for span counting
  bit obs_stall, obs_busy;

  always #5 clk = ~clk;

  stall_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .D_rs         (D_rs),
    .D_rt         (D_rt),
    .D_Tuse_rs    (D_Tuse_rs),
    .D_Tuse_rt    (D_Tuse_rt),
    .D_is_md      (D_is_md),
    .E_wa         (E_wa),
    .E_Tnew       (E_Tnew),
    .M_wa         (M_wa),
    .M_Tnew       (M_Tnew),
    .E_md_start   (E_md_start),
    .E_md_div     (E_md_div),
    .freeze       (freeze),
    .D_en         (D_en),
    .E_flush      (E_flush),
    .md_busy      (md_busy),
    .stall_cycles (stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Busy if a start is present now, or the last start lies within its latency window.
  function automatic bit m_busy();
    return E_md_start || (have_md && (cyc - md_start) <= md_lat);
  endfunction

  function automatic bit m_op_stall(input int src, input int tuse);
    bit hit_e, hit_m;
    hit_e = (src == int'(E_wa)) && (tuse < int'(E_Tnew));
    hit_m = (src == int'(M_wa)) && (tuse < int'(M_Tnew));
    return (src != 0) && (hit_e || hit_m);
  endfunction

  function automatic bit m_stall();
    return m_op_stall(int'(D_rs), int'(D_Tuse_rs)) ||
           m_op_stall(int'(D_rt), int'(D_Tuse_rt)) ||
           (D_is_md && m_busy());
  endfunction

  task automatic quiet();
    D_rs = 5'd0; D_rt = 5'd0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3; D_is_md = 1'b0;
    E_wa = 5'd0; E_Tnew = 2'd0; M_wa = 5'd0; M_Tnew = 2'd0;
    E_md_start = 1'b0; E_md_div = 1'b0;
  endtask

  // Called just after a negedge with inputs applied: check, then advance one clock.
  task automatic cycle_chk(input string tag);
    bit s, b;
    #2;
    s = m_stall();
    b = m_busy();
    obs_stall = freeze;
    obs_busy  = md_busy;
    chk({tag, "_freeze"},  32'(freeze),  32'(s));
    chk({tag, "_D_en"},    32'(D_en),    32'(!s));
    chk({tag, "_E_flush"}, 32'(E_flush), 32'(s));
    chk({tag, "_md_busy"}, 32'(md_busy), 32'(b));
    chk({tag, "_cnt"},     stall_cycles, m_cnt);
    @(posedge clk);
    if (reset) begin
      have_md = 1'b0;
      m_cnt   = 32'd0;
    end else begin
      if (s && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (E_md_start) begin
        have_md  = 1'b1;
        md_start = cyc;
        md_lat   = E_md_div ? 10 : 5;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int span_s, span_b;
    logic [31:0] c0;
    quiet();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    have_md = 1'b0; m_cnt = 32'd0;
    reset = 1'b0;

    // reset state with quiet inputs
    #2;
    chk("rst_freeze", 32'(freeze), 32'd0);
    chk("rst_D_en", 32'(D_en), 32'd1);
    chk("rst_E_flush", 32'(E_flush), 32'd0);
    chk("rst_md_busy", 32'(md_busy), 32'd0);
    chk("rst_cnt", stall_cycles, 32'd0);
    @(negedge clk);

    // 1: E-stage rs hazard
    c0 = m_cnt;
    E_wa = 5'd5; E_Tnew = 2'd2; D_rs = 5'd5; D_Tuse_rs = 2'd1;
    cycle_chk("t1");
    chk("t1_stall_seen", 32'(obs_stall), 32'd1);
    quiet();
    cycle_chk("t1b");
    chk("t1_cnt_inc", stall_cycles, c0 + 32'd1);

    // 2: register 0 never stalls; M-stage rt hazard does
    D_rs = 5'd0; E_wa = 5'd0; E_Tnew = 2'd2; D_Tuse_rs = 2'd0;
    cycle_chk("t2a");
    chk("t2a_nostall", 32'(obs_stall), 32'd0);
    quiet();
    M_wa = 5'd7; M_Tnew = 2'd1; D_rt = 5'd7; D_Tuse_rt = 2'd0;
    cycle_chk("t2b");
    chk("t2b_stall", 32'(obs_stall), 32'd1);
    quiet();

    // 3: mult with md instr held in D
    span_s = 0; span_b = 0;
    E_md_start = 1'b1; E_md_div = 1'b0; D_is_md = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle_chk("t3");
      span_s += int'(obs_stall);
      span_b += int'(obs_busy);
      E_md_start = 1'b0;
    end
    chk("t3_stall_span", 32'(span_s), 32'd6);
    chk("t3_busy_span", 32'(span_b), 32'd6);
    quiet();

    // 4: div, non-md instr in D
    span_s = 0; span_b = 0;
    E_md_start = 1'b1; E_md_div = 1'b1;
    for (int i = 0; i < 14; i++) begin
      cycle_chk("t4");
      span_s += int'(obs_stall);
      span_b += int'(obs_busy);
      E_md_start = 1'b0;
    end
    chk("t4_stall_span", 32'(span_s), 32'd0);
    chk("t4_busy_span", 32'(span_b), 32'd11);

    // 5: reset three cycles into a div
    E_md_start = 1'b1; E_md_div = 1'b1; D_is_md = 1'b1;
    cycle_chk("t5");
    E_md_start = 1'b0;
    cycle_chk("t5");
    cycle_chk("t5");
    reset = 1'b1;
    cycle_chk("t5r");
    reset = 1'b0;
    #2;
    chk("t5_busy_after", 32'(md_busy), 32'd0);
    chk("t5_cnt_after", stall_cycles, 32'd0);
    @(negedge clk);
    quiet();

    // 6: counter saturation
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    E_wa = 5'd5; E_Tnew = 2'd2; D_rs = 5'd5; D_Tuse_rs = 2'd1;
    repeat (3) cycle_chk("t6");
    quiet();
    cycle_chk("t6q");
    chk("t6_sat", stall_cycles, 32'hFFFF_FFFF);

    // randomized traffic
    reset = 1'b1;
    cycle_chk("rr");
    reset = 1'b0;
    for (int i = 0; i < 600; i++) begin
      D_rs       = 5'($urandom_range(0, 3));
      D_rt       = 5'($urandom_range(0, 3));
      D_Tuse_rs  = 2'($urandom_range(0, 3));
      D_Tuse_rt  = 2'($urandom_range(0, 3));
      E_wa       = 5'($urandom_range(0, 3));
      M_wa       = 5'($urandom_range(0, 3));
      E_Tnew     = 2'($urandom_range(0, 3));
      M_Tnew     = 2'($urandom_range(0, 3));
      D_is_md    = 1'($urandom_range(0, 1));
      E_md_start = ($urandom_range(0, 9) == 0);
      E_md_div   = 1'($urandom_range(0, 1));
      reset      = ($urandom_range(0, 59) == 0);
      cycle_chk("rnd");
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
